// File: rtl/alu_pkg.sv
// Shared types and constants for the Y86 ALU execute stage.
// Holds the datapath width, ALU function codes, condition-code reset value,
// the output-buffer entry layout and the buffer state encoding.
package alu_pkg;

  localparam int W = 64;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_XOR = 4'd3
  } alu_ifun_e;

  // {ZF, SF, OF} after reset: result "zero", not negative, no overflow.
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef struct packed {
    logic [W-1:0] valE;
    logic         err;
  } alu_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decode-to-execute and execute-to-memory handshake bundle.
// master: the decode/consumer side; slave: the execute stage itself.
interface alu_exec_stage_if;
  import alu_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_ifun;
  logic [W-1:0]  in_valA;
  logic [W-1:0]  in_valB;
  logic          in_set_cc;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_valE;
  logic          out_err;
  logic [2:0]    cc;

  modport master (
    output in_valid, in_ifun, in_valA, in_valB, in_set_cc, out_ready,
    input  in_ready, out_valid, out_valE, out_err, cc
  );

  modport slave (
    input  in_valid, in_ifun, in_valA, in_valB, in_set_cc, out_ready,
    output in_ready, out_valid, out_valE, out_err, cc
  );

endinterface

// File: rtl/alu_exec_stage_alu64.sv
// alu64: combinational 64-bit Y86 ALU computing valE = valB OP valA
// with ZF/SF/OF flags and an illegal-function indication (valE = 0 then).
module alu64
  import alu_pkg::*;
(
  input  logic [W-1:0] i_valA,
  input  logic [W-1:0] i_valB,
  input  logic [3:0]   i_ifun,
  output logic [W-1:0] o_valE,
  output logic         o_zf,
  output logic         o_sf,
  output logic         o_of,
  output logic         o_illegal
);

  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_and;
  logic [W-1:0] w_xor;

  // Independent arithmetic/logic units; carry out is discarded.
  assign w_sum  = i_valB + i_valA;
  assign w_diff = i_valB - i_valA;
  assign w_and  = i_valB & i_valA;
  assign w_xor  = i_valB ^ i_valA;

  // Select the unit result and derive signed overflow for add/sub.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_valE    = '0;
    o_of      = 1'b0;
    o_illegal = 1'b0;
    case (i_ifun)
      ALU_ADD: begin
        o_valE = w_sum;
        o_of   = (i_valA[W-1] == i_valB[W-1]) && (w_sum[W-1] != i_valB[W-1]);
      end
      ALU_SUB: begin
        o_valE = w_diff;
        o_of   = (i_valA[W-1] != i_valB[W-1]) && (w_diff[W-1] != i_valB[W-1]);
      end
      ALU_AND: o_valE = w_and;
      ALU_XOR: o_valE = w_xor;
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_zf = (o_valE == '0);
  assign o_sf = o_valE[W-1];

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered Y86 execute stage with a 2-entry output buffer.
// Results leave in acceptance order; in_ready depends only on registered state.
// Build option: define ALU_EXEC_CC_EN to build the condition-code register;
// otherwise cc is tied to CC_RESET and in_set_cc is ignored.
module alu_exec_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_exec_stage_if.slave  bus
);

  logic [W-1:0] w_valE;
  logic         w_zf;
  logic         w_sf;
  logic         w_of;
  logic         w_illegal;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_accept;
  logic         w_emit;
  logic         w_wr_idx;
  alu_entry_t   w_head_entry;

  buf_state_e   r_state;
  logic         r_head;
  alu_entry_t   r_entry [2];

  alu64 u_alu (
    .i_valA    (bus.in_valA),
    .i_valB    (bus.in_valB),
    .i_ifun    (bus.in_ifun),
    .o_valE    (w_valE),
    .o_zf      (w_zf),
    .o_sf      (w_sf),
    .o_of      (w_of),
    .o_illegal (w_illegal)
  );

  // Handshake decode: reset forces the idle view (ready, nothing valid).
  assign w_in_ready  = rst || (r_state != ST_TWO);
  assign w_out_valid = !rst && (r_state != ST_EMPTY);
  assign w_accept    = bus.in_valid && w_in_ready && !rst;
  assign w_emit      = w_out_valid && bus.out_ready;

  // A new entry goes behind the head when one is already held.
  assign w_wr_idx    = r_head ^ (r_state == ST_ONE);

  // Buffer occupancy FSM and head pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (rst) begin
      r_state <= ST_EMPTY;
      r_head  <= 1'b0;
    end else begin
      if (w_emit) r_head <= ~r_head;
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_emit)      r_state <= ST_TWO;
          else if (!w_accept && w_emit) r_state <= ST_EMPTY;
        end
        ST_TWO:   if (w_emit) r_state <= ST_ONE;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  // Result storage written on accept.
  always_ff @(posedge clk) begin
    // NOTE: entries carry no reset; out_valid gates them, so stale data never escapes.
    if (w_accept) r_entry[w_wr_idx] <= '{valE: w_valE, err: w_illegal};
  end

  assign w_head_entry  = r_entry[r_head];
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_valE  = w_out_valid ? w_head_entry.valE : '0;
  assign bus.out_err   = w_out_valid ? w_head_entry.err  : 1'b0;

`ifdef ALU_EXEC_CC_EN
  logic [2:0] r_cc;

  // Condition codes load on any legal accepted op that requests it.
  always_ff @(posedge clk) begin
    if (rst)                                          r_cc <= CC_RESET;
    else if (w_accept && bus.in_set_cc && !w_illegal) r_cc <= {w_zf, w_sf, w_of};
  end

  assign bus.cc = r_cc;
`else
  logic w_unused_cc;
  assign w_unused_cc = ^{w_zf, w_sf, w_of, bus.in_set_cc};
  assign bus.cc      = CC_RESET;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed test-plan cases with
// literal expectations, then randomized traffic against a queue-based model.
module tb_alu_exec_stage;
  import alu_pkg::*;

`ifdef ALU_EXEC_CC_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_stage_if bus ();

  alu_exec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] v;
    logic        err;
    logic [2:0]  fl;
  } res_t;

  res_t       q[$];
  logic [2:0] m_cc   = 3'b100;
  int         n_vec  = 0;
  int         n_err  = 0;
  bit         chk_en = 1'b0;

  // Reference: signed arithmetic on 65-bit sign-extended operands.
  function automatic res_t ref_op(logic [3:0] f, logic [63:0] a, logic [63:0] b);
    res_t        r;
    logic [64:0] s;
    logic        of;
    r.v = 64'd0; r.err = 1'b0; of = 1'b0; s = 65'd0;
    case (f)
      4'd0: begin s = {b[63], b} + {a[63], a}; r.v = s[63:0]; of = s[64] ^ s[63]; end
      4'd1: begin s = {b[63], b} - {a[63], a}; r.v = s[63:0]; of = s[64] ^ s[63]; end
      4'd2: r.v = b & a;
      4'd3: r.v = b ^ a;
      default: r.err = 1'b1;
    endcase
    r.fl = {r.v == 64'd0, r.v[63], of};
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_update();
    bit   acc, emi;
    res_t r;
    if (rst) begin
      q.delete();
      m_cc = 3'b100;
      return;
    end
    acc = bus.in_valid && (q.size() < 2);
    emi = (q.size() > 0) && bus.out_ready;
    if (emi) void'(q.pop_front());
    if (acc) begin
      r = ref_op(bus.in_ifun, bus.in_valA, bus.in_valB);
      q.push_back(r);
      if (CC_EN && bus.in_set_cc && !r.err) m_cc = r.fl;
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic        ev;
      logic [63:0] exp_v;
      logic        exp_e;
      ev    = !rst && (q.size() > 0);
      exp_v = 64'd0;
      exp_e = 1'b0;
      if (ev) begin
        exp_v = q[0].v;
        exp_e = q[0].err;
      end
      check("out_valid", bus.out_valid, ev);
      check("in_ready",  bus.in_ready,  rst || (q.size() < 2));
      check("out_valE",  bus.out_valE,  exp_v);
      check("out_err",   bus.out_err,   exp_e);
      check("cc",        bus.cc,        m_cc);
    end
  end

  task automatic step(logic r, logic iv, logic [3:0] f, logic [63:0] a, logic [63:0] b,
                      logic scc, logic ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_ifun   = f;
    bus.in_valA   = a;
    bus.in_valB   = b;
    bus.in_set_cc = scc;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic op(logic [3:0] f, logic [63:0] a, logic [63:0] b, logic scc, logic ordy);
    step(1'b0, 1'b1, f, a, b, scc, ordy);
  endtask

  task automatic idle(logic ordy);
    step(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, ordy);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    case ($urandom_range(0, 3))
      0:       v = {$urandom, $urandom};
      1:       v = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      2:       v = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 3));
      default: v = 64'($urandom_range(0, 8));
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] a, b;
    logic [3:0]  f;

    step(1'b1, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    chk_en = 1'b1;
    idle(1'b1);
    settle();
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst in_ready",  bus.in_ready,  1'b1);
    check("rst out_valE",  bus.out_valE,  64'd0);
    check("rst out_err",   bus.out_err,   1'b0);
    check("rst cc",        bus.cc,        3'b100);

    op(4'd3, 64'h3FF, 64'h368, 1'b1, 1'b1);
    settle();
    check("xor valE", bus.out_valE, 64'h097);
    check("xor cc",   bus.cc, CC_EN ? 3'b000 : 3'b100);

    op(4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    settle();
    check("add ovf valE", bus.out_valE, 64'h8000_0000_0000_0000);
    check("add ovf cc",   bus.cc, CC_EN ? 3'b011 : 3'b100);

    op(4'd1, 64'd5, 64'd5, 1'b0, 1'b1);
    settle();
    check("sub nocc valE", bus.out_valE, 64'd0);
    check("sub nocc cc",   bus.cc, CC_EN ? 3'b011 : 3'b100);

    op(4'd1, 64'd5, 64'd5, 1'b1, 1'b1);
    settle();
    check("sub eq cc", bus.cc, 3'b100);

    op(4'd3, 64'h3FF, 64'h368, 1'b1, 1'b1);
    op(4'd7, 64'h3FF, 64'h368, 1'b1, 1'b1);
    settle();
    check("illegal err",  bus.out_err,  1'b1);
    check("illegal valE", bus.out_valE, 64'd0);
    check("illegal cc",   bus.cc, CC_EN ? 3'b000 : 3'b100);
    idle(1'b1);
    settle();
    check("drained valid", bus.out_valid, 1'b0);

    // Backpressure: two absorbed, third held until space frees.
    op(4'd3, 64'h3FF, 64'h368, 1'b0, 1'b0);
    op(4'd0, 64'd1, 64'd2, 1'b0, 1'b0);
    settle();
    check("bp ready after 2", bus.in_ready, 1'b0);
    check("bp head xor",      bus.out_valE, 64'h097);
    op(4'd2, 64'hF0, 64'h3C, 1'b0, 1'b0);
    settle();
    check("bp still full", bus.in_ready, 1'b0);
    check("bp xor held",   bus.out_valE, 64'h097);
    op(4'd2, 64'hF0, 64'h3C, 1'b0, 1'b1);
    settle();
    check("bp 2nd add", bus.out_valE, 64'd3);
    op(4'd2, 64'hF0, 64'h3C, 1'b0, 1'b1);
    settle();
    check("bp 3rd and", bus.out_valE, 64'h30);
    idle(1'b1);
    settle();
    check("bp drained", bus.out_valid, 1'b0);

    // Reset with two entries buffered; in_valid during reset is ignored.
    op(4'd0, 64'd10, 64'd20, 1'b1, 1'b0);
    op(4'd1, 64'd10, 64'd20, 1'b1, 1'b0);
    step(1'b1, 1'b1, 4'd0, 64'd1, 64'd1, 1'b1, 1'b0);
    settle();
    check("mid rst valid", bus.out_valid, 1'b0);
    check("mid rst ready", bus.in_ready,  1'b1);
    check("mid rst cc",    bus.cc,        3'b100);
    check("mid rst valE",  bus.out_valE,  64'd0);
    idle(1'b1);
    settle();
    check("post rst valid", bus.out_valid, 1'b0);
    idle(1'b1);
    settle();
    check("no stale", bus.out_valid, 1'b0);

    // Randomized traffic; the every-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      f = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      a = rand64();
      b = ($urandom_range(0, 7) == 0) ? a : rand64();
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), f, a, b,
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    settle();
    check("final drained", bus.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage for the Y86 datapath. It accepts an operand pair and ALU function code from decode over a valid/ready handshake and computes valE = valB OP valA through the 64-bit combinational ALU (add, sub, and, xor). It updates the condition-code register and presents results to memory/write-back through a 2-entry output buffer, so the stage sustains full throughput under backpressure.

## Interface
- W, 64, datapath width; the stage is only defined for 64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  decode presents an operation.
- in_ready  out  1  stage can accept this cycle.
- in_ifun  in  4  0 = ADD, 1 = SUB, 2 = AND, 3 = XOR; 4–15 illegal.
- in_valA  in  64  operand A.
- in_valB  in  64  operand B.
- in_set_cc  in  1  update condition codes with this operation.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_valE  out  64  result.
- out_err  out  1  result came from an illegal ifun.
- cc  out  3  {ZF, SF, OF} condition-code register.

## Operation
- Function codes:
  - ADD: valB + valA.
  - SUB: valB − valA.
  - AND: valB & valA.
  - XOR: valB ^ valA.
  - All arithmetic is two's complement modulo 2^64; carry is discarded.
- Flags are computed from valE:
  - ZF = (valE == 0).
  - SF = valE[63].
  - OF for ADD = (A[63] == B[63]) && (valE[63] != B[63]).
  - OF for SUB = (A[63] != B[63]) && (valE[63] != B[63]).
  - OF = 0 for AND and XOR.
- Illegal ifun: valE = 0, out_err = 1, cc not updated (in_set_cc ignored).
- Transfer rules:
  - Accept = in_valid && in_ready.
  - Emit = out_valid && out_ready.
- Output buffer FSM:
  - EMPTY → ONE on accept.
  - ONE → TWO on accept without emit.
  - ONE → EMPTY on emit without accept.
  - ONE → ONE on accept and emit in the same cycle.
  - TWO → ONE on emit. No accept is possible in TWO.
- Ordering: results leave strictly in acceptance order. out_valE and out_err always come from the oldest entry.
- in_ready = (state != TWO), decoded from registered state only. It has no combinational path from out_ready.
- out_valid = (state != EMPTY).
- cc update: on accept with in_set_cc = 1 and a legal ifun, cc is loaded with the flags of that operation. This is independent of buffer state and downstream stall.
- Reset (at any time, including mid-operation) sets state EMPTY and discards buffered entries. cc = 3'b100 (ZF=1, SF=0, OF=0).
- Output values during and after reset:
  - out_valid = 0.
  - in_ready = 1.
  - out_valE = 0.
  - out_err = 0.
- in_valid asserted while rst is high is ignored.

## Timing
- Latency: an operation accepted at edge N is visible on out_* after edge N (out_valid = 1 from then on), when the buffer was EMPTY or emitting.
- cc reflects an operation from the cycle after its accept.
- Throughput: 1 operation per cycle while out_ready = 1.
- With out_ready = 0, two operations are absorbed. in_ready falls the cycle after the second accept.
- out_valE and out_err are held stable while out_valid = 1 and out_ready = 0.
- Accept and emit in the same cycle in ONE: the new entry becomes visible after the edge, with no bubble.

## Configuration
- Macro: ALU_EXEC_CC_EN.
- Defined: the cc register and flag logic are built as described above.
- Undefined:
  - No cc register or flag logic is built.
  - cc is tied to 3'b100.
  - in_set_cc is ignored.
  - The port list is unchanged, so integration is identical in both builds.

## Structure
- Package alu_pkg:
  - Width constant 64.
  - ifun enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR).
  - CC_RESET = 3'b100.
  - Packed entry typedef {valE, err}.
- Sub-module alu64: combinational; inputs valA, valB, ifun; outputs valE, zf, sf, of, illegal. It reuses the existing 64-bit add/sub/and/xor units.
- alu_exec_stage holds the FSM, two entry registers with head pointer, and the cc register.

## Test plan
- XOR: valA = 0x3FF, valB = 0x368, ifun = 3, set_cc = 1 → out_valE = 0x097 one cycle later; cc = 3'b000.
- ADD overflow: valA = 1, valB = 0x7FFF_FFFF_FFFF_FFFF, ifun = 0 → out_valE = 0x8000_0000_0000_0000; cc = {0,1,1}.
- SUB equal: valA = valB = 5, ifun = 1, set_cc = 1 → out_valE = 0; cc = {1,0,0}. Repeat with set_cc = 0 after ADD overflow → cc stays {0,1,1}.
- Backpressure: out_ready = 0; push XOR, ADD, AND back-to-back → in_ready = 0 after the second accept, third held. Raise out_ready → results emerge XOR, ADD, AND in order, one per cycle.
- Illegal ifun = 7, set_cc = 1 → out_err = 1, out_valE = 0, cc unchanged.
- Reset with two entries buffered → next cycle out_valid = 0, in_ready = 1, cc = 3'b100. No stale result is emitted afterwards.
